// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, lane/accumulator types and the result payload.
package cnn_pkg;

    localparam int unsigned LANES      = 16;
    localparam int unsigned DW         = 8;
    localparam int unsigned ACC_W      = 24;
    localparam int unsigned SUM_W      = ACC_W + 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned RES_W      = LANES * ACC_W + SUM_W;

    typedef logic signed [DW-1:0]    lane_t;
    typedef logic signed [2*DW-1:0]  prod_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    typedef struct packed {
        sum_t                   sum;
        logic [LANES*ACC_W-1:0] lanes;
    } res_t;

    function automatic acc_t sext_prod(input prod_t p);
        return {{(ACC_W - 2*DW){p[2*DW-1]}}, p};
    endfunction

    function automatic sum_t sext_acc(input acc_t a);
        return {{(SUM_W - ACC_W){a[ACC_W-1]}}, a};
    endfunction

endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is refused unless a pop frees a slot that cycle.
module conv_res_fifo
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = RES_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_pop  = 1'b0;
        do_push = 1'b0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            do_pop  = pop_i && !empty_o;
            do_push = push_i && (!full_o || do_pop);
            wr_d    = wr_q + (AW+1)'(do_push);
            rd_d    = rd_q + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/conv_mac_array.sv
// 16-lane signed MAC: product stage, window accumulators, registered lane adder tree,
// then a small result FIFO toward pooling/write-back.
module conv_mac_array
    import cnn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   mac_valid,
    input  logic                   mac_last,
    input  logic [LANES*DW-1:0]    img_data,
    input  logic [LANES*DW-1:0]    wgt_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [LANES*ACC_W-1:0] res_lanes,
    output logic [SUM_W-1:0]       res_sum,
    output logic                   busy,
    output logic                   err_overflow
);

    prod_t prod_d [LANES];
    prod_t prod_q [LANES];
    logic  s1_valid_q, s1_valid_d;
    logic  s1_last_q,  s1_last_d;

    acc_t  acc_q [LANES];
    acc_t  acc_d [LANES];
    acc_t  win_q [LANES];
    acc_t  win_d [LANES];
    logic  open_q, open_d;
    logic  win_valid_q, win_valid_d;

    logic [LANES*ACC_W-1:0] s3_lanes_q, s3_lanes_d;
    sum_t                   s3_sum_q,   s3_sum_d;
    logic                   s3_valid_q, s3_valid_d;

    logic  err_q, err_d;
    logic  fifo_full;
    logic  fifo_empty;
    res_t  push_data;
    res_t  head;

    // Lane multipliers: exact signed DW x DW products.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_t a;
        lane_t b;
        assign a         = lane_t'(img_data[g*DW +: DW]);
        assign b         = lane_t'(wgt_data[g*DW +: DW]);
        assign prod_d[g] = prod_t'(a) * prod_t'(b);
    end

    assign s1_valid_d = mac_valid && !flush;
    assign s1_last_d  = mac_valid && mac_last && !flush;

    // Accumulate; on the last term the completed window moves to win regs and acc restarts.
    always_comb begin
        open_d      = open_q;
        win_valid_d = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
            win_d[i] = win_q[i];
        end
        if (flush) begin
            open_d = 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                acc_d[i] = '0;
            end
        end else if (s1_valid_q) begin
            open_d      = !s1_last_q;
            win_valid_d = s1_last_q;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (s1_last_q) begin
                    win_d[i] = acc_q[i] + sext_prod(prod_q[i]);
                    acc_d[i] = '0;
                end else begin
                    acc_d[i] = acc_q[i] + sext_prod(prod_q[i]);
                end
            end
        end
    end

    // Cross-lane adder tree; SUM_W leaves headroom for 16 full-scale lanes.
    always_comb begin
        s3_valid_d = win_valid_q && !flush;
        s3_lanes_d = s3_lanes_q;
        s3_sum_d   = s3_sum_q;
        if (win_valid_q) begin
            s3_sum_d = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s3_lanes_d[i*ACC_W +: ACC_W] = win_q[i];
                s3_sum_d = s3_sum_d + sext_acc(win_q[i]);
            end
        end
    end

    // A push meeting a full FIFO without a same-cycle pop is dropped and flagged.
    assign err_d = flush ? 1'b0 : (err_q || (s3_valid_q && fifo_full && !res_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            open_q      <= 1'b0;
            win_valid_q <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_lanes_q  <= '0;
            s3_sum_q    <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
                win_q[i]  <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            open_q      <= open_d;
            win_valid_q <= win_valid_d;
            s3_valid_q  <= s3_valid_d;
            s3_lanes_q  <= s3_lanes_d;
            s3_sum_q    <= s3_sum_d;
            err_q       <= err_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (s1_valid_d) begin
                    prod_q[i] <= prod_d[i];
                end
                acc_q[i] <= acc_d[i];
                win_q[i] <= win_d[i];
            end
        end
    end

    always_comb begin
        push_data       = '0;
        push_data.sum   = s3_sum_q;
        push_data.lanes = s3_lanes_q;
    end

    conv_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (s3_valid_q),
        .pop_i   (res_ready),
        .data_i  (push_data),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign res_valid    = !fifo_empty;
    assign res_lanes    = head.lanes;
    assign res_sum      = head.sum;
    assign err_overflow = err_q;
    assign busy         = s1_valid_q || open_q || win_valid_q || s3_valid_q || !fifo_empty;

endmodule
